// File: rtl/flash_pkg.sv
// Shared constants and encodings for the bound-flasher lamp bus.
// Used by the lamp monitor and the flasher bench.
package flash_pkg;

  localparam int MX_LP = 16;
  localparam int LVL_W = 5;
  localparam int CNT_W = 8;

  localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
  localparam logic [LVL_W-1:0] LVL_ONE  = {{(LVL_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    DIR_IDLE   = 2'b00,
    DIR_UP     = 2'b01,
    DIR_DOWN   = 2'b10,
    DIR_RESYNC = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_THERMO = 2'b01,
    ERR_JUMP   = 2'b10,
    ERR_STALL  = 2'b11
  } err_e;

  // Thermometer pattern with the lowest n lamps lit.
  function automatic logic [MX_LP-1:0] lvl2lamp(input logic [LVL_W-1:0] n);
    logic [MX_LP:0] one;
    logic [MX_LP:0] t;
    one = {{MX_LP{1'b0}}, 1'b1};
    t   = (one << n) - one;
    return t[MX_LP-1:0];
  endfunction

endpackage

// File: rtl/lamp_monitor_if.sv
// Lamp bus observation interface: sampled lamp vector and decoded status.
interface lamp_monitor_if;
  import flash_pkg::*;

  logic [MX_LP-1:0] lamp;
  logic             err_clr;
  logic [LVL_W-1:0] lvl;
  dir_e             dir;
  logic             turn;
  logic [LVL_W-1:0] turn_lvl;
  logic             land;
  logic [CNT_W-1:0] land_cnt;
  logic             err;
  err_e             err_code;

  modport master (
    output lamp, err_clr,
    input  lvl, dir, turn, turn_lvl, land, land_cnt, err, err_code
  );

  modport slave (
    input  lamp, err_clr,
    output lvl, dir, turn, turn_lvl, land, land_cnt, err, err_code
  );

endinterface

// File: rtl/lamp_monitor_thermo_decode.sv
// Combinational thermometer decoder: legal when lamp is 2^n-1, lvl = n.
module thermo_decode
  import flash_pkg::*;
(
  input  logic [MX_LP-1:0] lamp,
  output logic             legal,
  output logic [LVL_W-1:0] lvl
);

  logic [MX_LP-1:0] inc_s;

  // A thermometer code has no set bit above its lowest zero; all-ones wraps to 0.
  always_comb begin
    inc_s = lamp + {{(MX_LP-1){1'b0}}, 1'b1};
    legal = ((lamp & inc_s) == {MX_LP{1'b0}});
    lvl   = LVL_ZERO;
    for (int i = 0; i < MX_LP; i++) begin
      lvl = lvl + LVL_W'(lamp[i]);
    end
  end

endmodule

// File: rtl/lamp_monitor.sv
// Lamp bus monitor: decodes fill level and direction, reports reversals,
// landings and protocol errors one cycle after each sample.
module lamp_monitor
  import flash_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  lamp_monitor_if.slave bus
);

  logic             legal_s;
  logic [LVL_W-1:0] n_s;

  logic             up1_s, dn1_s, same_s, zero_s;
  logic             err_det_s;
  err_e             new_code_s;

  dir_e             state_q, state_d;
  logic [LVL_W-1:0] prev_lvl_q, prev_lvl_d;
  logic             turn_q, turn_d;
  logic [LVL_W-1:0] turn_lvl_q, turn_lvl_d;
  logic             land_q, land_d;
  logic [CNT_W-1:0] land_cnt_q, land_cnt_d;
  logic             err_q, err_d;
  err_e             err_code_q, err_code_d;

  thermo_decode u_dec (
    .lamp  (bus.lamp),
    .legal (legal_s),
    .lvl   (n_s)
  );

  // Step comparator against the last legal level.
  always_comb begin
    up1_s  = (n_s == (prev_lvl_q + LVL_ONE));
    dn1_s  = (prev_lvl_q != LVL_ZERO) && (n_s == (prev_lvl_q - LVL_ONE));
    same_s = (n_s == prev_lvl_q);
    zero_s = (n_s == LVL_ZERO);
  end

  // Error classification; THERMO masks the step checks, RESYNC masks everything.
  always_comb begin
    err_det_s  = 1'b0;
    new_code_s = ERR_NONE;
    if (state_q == DIR_RESYNC) begin
      err_det_s = 1'b0;
    end else if (!legal_s) begin
      err_det_s  = 1'b1;
      new_code_s = ERR_THERMO;
    end else if (state_q == DIR_IDLE) begin
      if (!zero_s && (n_s != LVL_ONE)) begin
        err_det_s  = 1'b1;
        new_code_s = ERR_JUMP;
      end else begin
        err_det_s = 1'b0;
      end
    end else if (up1_s || dn1_s || (same_s && zero_s)) begin
      err_det_s = 1'b0;
    end else if (same_s) begin
      err_det_s  = 1'b1;
      new_code_s = ERR_STALL;
    end else begin
      err_det_s  = 1'b1;
      new_code_s = ERR_JUMP;
    end
  end

  // Next-state, pulse and status computation.
  always_comb begin
    state_d    = state_q;
    turn_d     = 1'b0;
    land_d     = 1'b0;
    turn_lvl_d = turn_lvl_q;
    land_cnt_d = land_cnt_q;
    prev_lvl_d = legal_s ? n_s : prev_lvl_q;

    if (err_det_s) begin
      state_d = DIR_RESYNC;
    end else begin
      case (state_q)
        DIR_IDLE: begin
          if (n_s == LVL_ONE) begin
            state_d = DIR_UP;
          end else begin
            state_d = DIR_IDLE;
          end
        end
        DIR_UP: begin
          if (dn1_s) begin
            state_d    = DIR_DOWN;
            turn_d     = 1'b1;
            turn_lvl_d = prev_lvl_q;
          end else begin
            state_d = DIR_UP;
          end
        end
        DIR_DOWN: begin
          if (dn1_s && zero_s) begin
            state_d    = DIR_IDLE;
            land_d     = 1'b1;
            land_cnt_d = (land_cnt_q == CNT_MAX) ? land_cnt_q : land_cnt_q + CNT_ONE;
          end else if (up1_s) begin
            state_d    = DIR_UP;
            turn_d     = 1'b1;
            turn_lvl_d = prev_lvl_q;
          end else begin
            state_d = DIR_DOWN;
          end
        end
        DIR_RESYNC: begin
          if (legal_s && zero_s) begin
            state_d = DIR_IDLE;
          end else begin
            state_d = DIR_RESYNC;
          end
        end
        default: begin
          state_d = DIR_RESYNC;
        end
      endcase
    end

    // A new error overrides a simultaneous clear and reloads the code.
    if (err_det_s) begin
      err_d      = 1'b1;
      err_code_d = (bus.err_clr || (err_code_q == ERR_NONE)) ? new_code_s : err_code_q;
    end else if (bus.err_clr) begin
      err_d      = 1'b0;
      err_code_d = ERR_NONE;
    end else begin
      err_d      = err_q;
      err_code_d = err_code_q;
    end
  end

  // State and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DIR_IDLE;
      prev_lvl_q <= LVL_ZERO;
      turn_q     <= 1'b0;
      turn_lvl_q <= LVL_ZERO;
      land_q     <= 1'b0;
      land_cnt_q <= {CNT_W{1'b0}};
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      prev_lvl_q <= prev_lvl_d;
      turn_q     <= turn_d;
      turn_lvl_q <= turn_lvl_d;
      land_q     <= land_d;
      land_cnt_q <= land_cnt_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.lvl      = prev_lvl_q;
  assign bus.dir      = state_q;
  assign bus.turn     = turn_q;
  assign bus.turn_lvl = turn_lvl_q;
  assign bus.land     = land_q;
  assign bus.land_cnt = land_cnt_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;

endmodule

// File: tb/tb_lamp_monitor.sv
// Directed self-checking bench for lamp_monitor.
module tb_lamp_monitor;
  import flash_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  lamp_monitor_if bus ();

  lamp_monitor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_chk  = 0;
  int   n_pass = 0;
  int   cur    = 0;
  int   n_land = 0;
  int   n_both = 0;
  int   turns[$];
  dir_e dirs[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input logic [MX_LP-1:0] l);
    bus.lamp = l;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ev();
    turns.delete();
    dirs.delete();
    n_land = 0;
    n_both = 0;
    dirs.push_back(bus.dir);
  endtask

  task automatic sweep_to(input int target);
    while (cur != target) begin
      cur = (target > cur) ? cur + 1 : cur - 1;
      step(lvl2lamp(LVL_W'(cur)));
      if (bus.turn) turns.push_back(int'(bus.turn_lvl));
      if (bus.land) n_land++;
      if (bus.turn && bus.land) n_both++;
      if (bus.dir != dirs[$]) dirs.push_back(bus.dir);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.lamp    = 16'h0000;
    bus.err_clr = 1'b0;
    #12;
    chk("rst_lvl", 32'(bus.lvl), 32'd0);
    chk("rst_dir", 32'(bus.dir), 32'd0);
    chk("rst_err", 32'({bus.err, bus.err_code}), 32'd0);
    chk("rst_cnt", 32'({bus.land_cnt, bus.turn_lvl, bus.turn, bus.land}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full sweep
    step(16'h0000);
    clr_ev();
    sweep_to(16);
    chk("sweep_top_lvl", 32'(bus.lvl), 32'd16);
    chk("sweep_top_dir", 32'(bus.dir), 32'(DIR_UP));
    sweep_to(0);
    chk("sweep_turns", 32'(turns.size()), 32'd1);
    chk("sweep_turn_lvl", 32'(turns[0]), 32'd16);
    chk("sweep_lands", 32'(n_land), 32'd1);
    chk("sweep_land_cnt", 32'(bus.land_cnt), 32'd1);
    chk("sweep_err", 32'(bus.err), 32'd0);
    chk("sweep_both", 32'(n_both), 32'd0);

    // Bounce 0->16->6->11->0
    clr_ev();
    sweep_to(16);
    sweep_to(6);
    sweep_to(11);
    sweep_to(0);
    chk("bounce_turns", 32'(turns.size()), 32'd3);
    chk("bounce_t0", 32'(turns[0]), 32'd16);
    chk("bounce_t1", 32'(turns[1]), 32'd6);
    chk("bounce_t2", 32'(turns[2]), 32'd11);
    chk("bounce_lands", 32'(n_land), 32'd1);
    chk("bounce_land_cnt", 32'(bus.land_cnt), 32'd2);
    chk("bounce_ndir", 32'(dirs.size()), 32'd6);
    chk("bounce_dirs", 32'({dirs[0], dirs[1], dirs[2], dirs[3], dirs[4], dirs[5]}),
        32'({DIR_IDLE, DIR_UP, DIR_DOWN, DIR_UP, DIR_DOWN, DIR_IDLE}));
    chk("bounce_both", 32'(n_both), 32'd0);

    // Non-thermometer sample while in UP at level 3
    sweep_to(3);
    step(16'h0005);
    chk("thermo_err", 32'(bus.err), 32'd1);
    chk("thermo_code", 32'(bus.err_code), 32'(ERR_THERMO));
    chk("thermo_dir", 32'(bus.dir), 32'(DIR_RESYNC));
    chk("thermo_lvl", 32'(bus.lvl), 32'd3);
    step(16'h0000);
    cur = 0;
    chk("resync_dir", 32'(bus.dir), 32'(DIR_IDLE));
    chk("resync_land", 32'(bus.land), 32'd0);
    chk("resync_err", 32'(bus.err), 32'd1);
    chk("resync_cnt", 32'(bus.land_cnt), 32'd2);

    // Clear alone
    bus.err_clr = 1'b1;
    step(16'h0000);
    bus.err_clr = 1'b0;
    chk("clr_err", 32'({bus.err, bus.err_code}), 32'd0);

    // Jump, then stall keeps the first code
    sweep_to(3);
    step(16'h003F);
    chk("jump_code", 32'(bus.err_code), 32'(ERR_JUMP));
    chk("jump_dir", 32'(bus.dir), 32'(DIR_RESYNC));
    chk("jump_lvl", 32'(bus.lvl), 32'd6);
    step(16'h0000);
    chk("jump_idle", 32'(bus.dir), 32'(DIR_IDLE));
    step(16'h0001);
    step(16'h0003);
    step(16'h0003);
    chk("stall_keep_code", 32'(bus.err_code), 32'(ERR_JUMP));
    chk("stall_dir", 32'(bus.dir), 32'(DIR_RESYNC));
    step(16'h0000);

    // Clear coinciding with a stall
    bus.err_clr = 1'b1;
    step(16'h0000);
    bus.err_clr = 1'b0;
    chk("clr2_err", 32'(bus.err), 32'd0);
    step(16'h0001);
    step(16'h0003);
    bus.err_clr = 1'b1;
    step(16'h0003);
    bus.err_clr = 1'b0;
    chk("clr_stall_err", 32'(bus.err), 32'd1);
    chk("clr_stall_code", 32'(bus.err_code), 32'(ERR_STALL));
    step(16'h0000);
    bus.err_clr = 1'b1;
    step(16'h0000);
    bus.err_clr = 1'b0;
    cur = 0;

    // Asynchronous reset mid-UP
    step(16'h0001);
    step(16'h0003);
    rst_n = 1'b0;
    #2;
    chk("midrst_lvl_dir", 32'({bus.lvl, bus.dir}), 32'd0);
    chk("midrst_cnt", 32'(bus.land_cnt), 32'd0);
    chk("midrst_turn_lvl", 32'(bus.turn_lvl), 32'd0);
    #2;
    rst_n = 1'b1;
    step(16'h0003);
    chk("post_rst_jump", 32'(bus.err_code), 32'(ERR_JUMP));
    chk("post_rst_dir", 32'(bus.dir), 32'(DIR_RESYNC));
    step(16'h0000);
    bus.err_clr = 1'b1;
    step(16'h0000);
    bus.err_clr = 1'b0;
    cur = 0;

    // Saturation over 256 sweeps
    clr_ev();
    repeat (256) begin
      sweep_to(16);
      sweep_to(0);
    end
    chk("sat_cnt", 32'(bus.land_cnt), 32'd255);
    chk("sat_lands", 32'(n_land), 32'd256);
    chk("sat_turns", 32'(turns.size()), 32'd256);
    chk("sat_err", 32'(bus.err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
